// File: rtl/pifo_dequeue_ctrl_v0_1_if.sv
// AXI-stream output channel of the PIFO dequeue controller.
interface pifo_dequeue_ctrl_v0_1_if #(
  parameter int unsigned DATA_WIDTH = 31
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pifo_dequeue_ctrl_v0_1.sv
// PIFO dequeue controller: pops the head atom into an AXI-stream register, or discards all entries on flush.
// Optional statistics counters are enabled by defining PIFO_DEQ_STATS_EN.
module pifo_dequeue_ctrl_v0_1 #(
  parameter int unsigned ELEMENT_WIDTH           = 32,
  parameter int unsigned ELEMENT_RANK_WIDTH      = 18,
  parameter int unsigned PIFO_INFO_ADDRESS_WIDTH = 12,
  parameter int unsigned CNT_WIDTH               = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ELEMENT_WIDTH-1:0] in_pifo_head,
  input  logic                     in_deq_enable,
  input  logic                     in_flush,
  output logic                     out_ctl_pop,
  output logic                     out_global_overflow_bit,
  output logic                     out_busy,
`ifdef PIFO_DEQ_STATS_EN
  output logic [CNT_WIDTH-1:0]     out_pop_count,
  output logic [CNT_WIDTH-1:0]     out_stall_count,
`endif
  pifo_dequeue_ctrl_v0_1_if.master m_axis
);

  localparam int unsigned VALID_BIT     = ELEMENT_WIDTH - 1;
  localparam int unsigned PAYLOAD_WIDTH = 1 + ELEMENT_RANK_WIDTH + PIFO_INFO_ADDRESS_WIDTH;
  localparam int unsigned OVF_BIT       = PAYLOAD_WIDTH - 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t state;
  logic   head_valid;
  logic   slot_free;

  assign head_valid = in_pifo_head[VALID_BIT];
  assign slot_free  = ~m_axis.tvalid | m_axis.tready;
  assign out_busy   = rstn & (state == ST_FLUSH);

  // Pop strobe: flush drains the whole queue regardless of downstream backpressure.
  always_comb begin
    out_ctl_pop = 1'b0;
    if (rstn) begin
      if (state == ST_RUN) begin
        out_ctl_pop = head_valid & in_deq_enable & slot_free & ~in_flush;
      end else begin
        out_ctl_pop = head_valid;
      end
    end
  end

  // State, output register and overflow broadcast.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state                   <= ST_RUN;
      m_axis.tvalid           <= 1'b0;
      m_axis.tdata            <= '0;
      out_global_overflow_bit <= 1'b0;
    end else begin
      if (out_ctl_pop) begin
        out_global_overflow_bit <= in_pifo_head[OVF_BIT];
      end
      case (state)
        ST_RUN: begin
          if (out_ctl_pop) begin
            m_axis.tdata  <= in_pifo_head[PAYLOAD_WIDTH-1:0];
            m_axis.tvalid <= 1'b1;
          end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
          end
          if (in_flush) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Held element is dropped along with everything popped while draining.
          m_axis.tvalid <= 1'b0;
          if (!head_valid) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PIFO_DEQ_STATS_EN
  // Pop and backpressure statistics, wrapping at 2^CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_pop_count   <= '0;
      out_stall_count <= '0;
    end else begin
      if (out_ctl_pop) begin
        out_pop_count <= out_pop_count + CNT_WIDTH'(1);
      end
      if (m_axis.tvalid & ~m_axis.tready) begin
        out_stall_count <= out_stall_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pifo_dequeue_ctrl_v0_1.sv
// Bench for pifo_dequeue_ctrl_v0_1: vector table, reference model with output scoreboard, flush/reset sequences.
module tb_pifo_dequeue_ctrl_v0_1;

  localparam int unsigned EW = 32;
  localparam int unsigned DW = 31;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [EW-1:0] head;
  logic          en;
  logic          flush;
  logic          pop;
  logic          ovf;
  logic          busy;
`ifdef PIFO_DEQ_STATS_EN
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  pifo_dequeue_ctrl_v0_1_if #(.DATA_WIDTH(DW)) axis ();

  pifo_dequeue_ctrl_v0_1 #(
    .ELEMENT_WIDTH(EW), .ELEMENT_RANK_WIDTH(18), .PIFO_INFO_ADDRESS_WIDTH(12), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .in_pifo_head(head), .in_deq_enable(en), .in_flush(flush),
    .out_ctl_pop(pop), .out_global_overflow_bit(ovf), .out_busy(busy),
`ifdef PIFO_DEQ_STATS_EN
    .out_pop_count(pop_cnt), .out_stall_count(stall_cnt),
`endif
    .m_axis(axis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_flush_st = 1'b0;
  bit            m_tvalid   = 1'b0;
  bit            m_ovf      = 1'b0;
  logic [CW-1:0] m_pops     = '0;
  logic [CW-1:0] m_stalls   = '0;
  logic [DW-1:0] sb[$];
  logic [EW-1:0] pq[$];
  bit            last_pop;

  typedef struct {
    logic [EW-1:0] head;
    bit            en;
    bit            flush;
    bit            rdy;
    bit            pop;
    bit            tvalid;
    logic [DW-1:0] tdata;
    bit            ovf;
    bit            busy;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [EW-1:0] mk(input bit o);
    return {1'b1, o, 30'($urandom)};
  endfunction

  // One clock: drive, check comb pop, score output transfer, advance model, check registers.
  task automatic step(input bit r_n, input logic [EW-1:0] h, input bit e, input bit f, input bit rdy);
    bit hv;
    bit exp_pop;
    @(negedge clk);
    rstn = r_n; head = h; en = e; flush = f; axis.tready = rdy;
    #1;
    hv = h[EW-1];
    if (!r_n)             exp_pop = 1'b0;
    else if (!m_flush_st) exp_pop = hv & e & (~m_tvalid | rdy) & ~f;
    else                  exp_pop = hv;
    check("ctl_pop", 64'(pop), 64'(exp_pop));
    check("busy_pre", 64'(busy), 64'(r_n & m_flush_st));
    last_pop = pop;
    if (r_n && m_tvalid) begin
      if (rdy) begin
        if (sb.size() == 0) fail("scoreboard_underflow");
        else begin
          check("tdata_xfer", 64'(axis.tdata), 64'(sb[0]));
          void'(sb.pop_front());
        end
      end else if (m_flush_st && sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
    if (r_n && exp_pop && !m_flush_st) sb.push_back(h[DW-1:0]);
    if (!r_n) begin
      sb.delete();
      m_flush_st = 1'b0; m_tvalid = 1'b0; m_ovf = 1'b0; m_pops = '0; m_stalls = '0;
    end else begin
      if (m_tvalid && !rdy) m_stalls = m_stalls + CW'(1);
      if (exp_pop) begin
        m_pops = m_pops + CW'(1);
        m_ovf  = h[EW-2];
      end
      if (!m_flush_st) begin
        if (exp_pop)  m_tvalid = 1'b1;
        else if (rdy) m_tvalid = 1'b0;
        if (f) m_flush_st = 1'b1;
      end else begin
        m_tvalid = 1'b0;
        if (!hv) m_flush_st = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("tvalid", 64'(axis.tvalid), 64'(m_tvalid));
    check("busy", 64'(busy), 64'(r_n & m_flush_st));
    check("overflow_bit", 64'(ovf), 64'(m_ovf));
    if (m_tvalid) begin
      if (sb.size() == 0) fail("scoreboard_empty_while_valid");
      else check("tdata_hold", 64'(axis.tdata), 64'(sb[0]));
    end
`ifdef PIFO_DEQ_STATS_EN
    check("pop_count", 64'(pop_cnt), 64'(m_pops));
    check("stall_count", 64'(stall_cnt), 64'(m_stalls));
`endif
  endtask

  // Step driven from the bench-side PIFO; the head leaves it when the DUT pops.
  task automatic qstep(input bit e, input bit f, input bit rdy);
    logic [EW-1:0] h;
    h = (pq.size() != 0) ? pq[0] : '0;
    step(1'b1, h, e, f, rdy);
    if (last_pop && pq.size() != 0) void'(pq.pop_front());
  endtask

  initial begin
    int busy_cycles;
    int flush_pops;
    int guard;
    int inserted;
    rstn = 1'b0; head = '0; en = 1'b0; flush = 1'b0; axis.tready = 1'b0;

    //            head            en fl rdy pop tv  tdata           ovf busy
    tbl[0]  = '{32'h8000_5003, 1, 0, 1,  1,  1, 31'h0000_5003, 0,  0};
    tbl[1]  = '{32'hC000_1001, 1, 0, 1,  1,  1, 31'h4000_1001, 1,  0};
    tbl[2]  = '{32'h8000_2002, 1, 0, 1,  1,  1, 31'h0000_2002, 0,  0};
    tbl[3]  = '{32'h0000_0000, 1, 0, 1,  0,  0, 31'h0000_0000, 0,  0};
    tbl[4]  = '{32'h8000_7007, 0, 0, 1,  0,  0, 31'h0000_0000, 0,  0};
    tbl[5]  = '{32'h8000_7007, 1, 0, 0,  1,  1, 31'h0000_7007, 0,  0};
    tbl[6]  = '{32'h8000_8008, 1, 0, 0,  0,  1, 31'h0000_7007, 0,  0};
    tbl[7]  = '{32'h8000_8008, 1, 0, 0,  0,  1, 31'h0000_7007, 0,  0};
    tbl[8]  = '{32'h8000_8008, 1, 0, 0,  0,  1, 31'h0000_7007, 0,  0};
    tbl[9]  = '{32'h8000_8008, 1, 0, 1,  1,  1, 31'h0000_8008, 0,  0};
    tbl[10] = '{32'h0000_0000, 1, 0, 1,  0,  0, 31'h0000_0000, 0,  0};

    // Reset with a valid, enabled head: no pop may escape.
    step(1'b0, 32'h8000_5003, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h8000_5003, 1'b1, 1'b1, 1'b1);
    check("reset_tdata", 64'(axis.tdata), 64'(0));

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].head, tbl[i].en, tbl[i].flush, tbl[i].rdy);
      check($sformatf("vec%0d_pop", i), 64'(last_pop), 64'(tbl[i].pop));
      check($sformatf("vec%0d_tvalid", i), 64'(axis.tvalid), 64'(tbl[i].tvalid));
      if (tbl[i].tvalid) check($sformatf("vec%0d_tdata", i), 64'(axis.tdata), 64'(tbl[i].tdata));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
    end

    // Enable held low for 10 cycles, then pop in the re-enable cycle.
    pq = '{32'h8000_A00A, 32'h8000_B00B};
    for (int i = 0; i < 10; i++) qstep(1'b0, 1'b0, 1'b1);
    qstep(1'b1, 1'b0, 1'b1);
    check("reenable_pop", 64'(last_pop), 64'(1));
    for (int i = 0; i < 3; i++) qstep(1'b1, 1'b0, 1'b1);

    // Flush with a held element and 4 queued entries; a repeated flush pulse is ignored.
    pq = '{mk(1'b0), mk(1'b1), mk(1'b0), mk(1'b1), mk(1'b0)};
    qstep(1'b1, 1'b0, 1'b0);
    qstep(1'b1, 1'b1, 1'b0);
    check("flush_cycle_pop", 64'(last_pop), 64'(0));
    busy_cycles = 0;
    flush_pops  = 0;
    guard       = 0;
    while (busy && guard < 12) begin
      busy_cycles++;
      qstep(1'b1, (guard == 1), 1'b0);
      if (last_pop) flush_pops++;
      guard++;
    end
    check("flush_busy_cycles", 64'(busy_cycles), 64'(5));
    check("flush_pops", 64'(flush_pops), 64'(4));
    check("flush_queue_empty", 64'(pq.size()), 64'(0));
    qstep(1'b1, 1'b0, 1'b1);

    // Randomised stream with backpressure and concurrent inserts.
    for (int i = 0; i < 30; i++) pq.push_back(mk(1'($urandom)));
    inserted = 0;
    guard    = 0;
    while ((pq.size() != 0 || m_tvalid || inserted < 20) && guard < 800) begin
      if (inserted < 20 && ($urandom % 3) == 0) begin
        pq.push_back(mk(1'($urandom)));
        inserted++;
      end
      qstep(($urandom % 8) != 0, 1'b0, ($urandom % 4) != 0);
      guard++;
    end
    if (guard >= 800) fail("stream_timeout");

    // Reset in the middle of a flush that dropped a held element.
    pq = '{mk(1'b1), mk(1'b1), mk(1'b1), mk(1'b1)};
    qstep(1'b1, 1'b0, 1'b0);
    qstep(1'b1, 1'b1, 1'b0);
    qstep(1'b1, 1'b0, 1'b0);
    check("pre_reset_busy", 64'(busy), 64'(1));
    check("pre_reset_ovf", 64'(ovf), 64'(1));
    step(1'b0, pq[0], 1'b1, 1'b0, 1'b0);
    check("mid_flush_reset_tvalid", 64'(axis.tvalid), 64'(0));
    check("mid_flush_reset_busy", 64'(busy), 64'(0));
    check("mid_flush_reset_ovf", 64'(ovf), 64'(0));
`ifdef PIFO_DEQ_STATS_EN
    check("mid_flush_reset_pops", 64'(pop_cnt), 64'(0));
    check("mid_flush_reset_stalls", 64'(stall_cnt), 64'(0));
`endif
    guard = 0;
    while ((pq.size() != 0 || m_tvalid) && guard < 20) begin
      qstep(1'b1, 1'b0, 1'b1);
      guard++;
    end
    if (guard >= 20) fail("drain_timeout");
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
